// File: rtl/cpu_bus_pkg.sv
// Shared datapath bus definitions: source indices matching the CPU datapath
// encoder strobes, default sizes and the index-width helper.
package cpu_bus_pkg;

  localparam int NSRC_DEFAULT  = 21;
  localparam int WIDTH_DEFAULT = 32;

  localparam int SRC_PC    = 0;
  localparam int SRC_IR    = 1;
  localparam int SRC_R0    = 2;
  localparam int SRC_R1    = 3;
  localparam int SRC_R2    = 4;
  localparam int SRC_R3    = 5;
  localparam int SRC_R4    = 6;
  localparam int SRC_R5    = 7;
  localparam int SRC_R6    = 8;
  localparam int SRC_R7    = 9;
  localparam int SRC_R8    = 10;
  localparam int SRC_R9    = 11;
  localparam int SRC_R10   = 12;
  localparam int SRC_R11   = 13;
  localparam int SRC_R12   = 14;
  localparam int SRC_R13   = 15;
  localparam int SRC_R14   = 16;
  localparam int SRC_R15   = 17;
  localparam int SRC_MDR   = 18;
  localparam int SRC_IP    = 19;
  localparam int SRC_CSIGN = 20;

  // A single-source bus still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Combinational priority encoder over the bus output-enable strobes:
// highest set index wins, plus any-set and two-or-more-set flags.
module bus_prio_enc
  import cpu_bus_pkg::*;
#(
  parameter  int NSRC  = NSRC_DEFAULT,
  localparam int IDX_W = idx_width(NSRC)
) (
  input  logic [NSRC-1:0]  sel,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Ascending scan so the last (highest) set bit overrides earlier ones;
  // multi rises when a set bit is seen after another one already was.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      multi = multi | (any & sel[i]);
      any   = any | sel[i];
      idx   = sel[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer with highest-index priority, hold on
// idle, and conflict logging (pulse, sticky flag, saturating counter).
module bus_mux_reg
  import cpu_bus_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int NSRC  = NSRC_DEFAULT,
  parameter  int CNT_W = 8,
  localparam int IDX_W = idx_width(NSRC)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NSRC*WIDTH-1:0] busi,
  input  logic [NSRC-1:0]       sel,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      buso,
  output logic                  buso_valid,
  output logic [IDX_W-1:0]      src_idx,
  output logic                  conflict,
  output logic                  conflict_sticky,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  logic             multi_s;
  logic [WIDTH-1:0] win_data_s;
  logic [CNT_W-1:0] cnt_base_s;

  bus_prio_enc #(
    .NSRC (NSRC)
  ) u_enc (
    .sel   (sel),
    .idx   (idx_s),
    .any   (any_s),
    .multi (multi_s)
  );

  // Pick the winning source word; compare-select keeps the index in range.
  always_comb begin
    win_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      win_data_s = (idx_s == IDX_W'(i)) ? busi[i*WIDTH +: WIDTH] : win_data_s;
    end
  end

  // err_clr is applied before a same-cycle conflict is logged.
  always_comb begin
    if (err_clr) begin
      cnt_base_s = {CNT_W{1'b0}};
    end else begin
      cnt_base_s = conflict_cnt;
    end
  end

  // Output register, conflict pulse, sticky flag and saturating counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      buso            <= {WIDTH{1'b0}};
      buso_valid      <= 1'b0;
      src_idx         <= {IDX_W{1'b0}};
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (any_s) begin
        buso    <= win_data_s;
        src_idx <= idx_s;
      end else begin
        buso    <= buso;
        src_idx <= src_idx;
      end
      buso_valid <= any_s;
      conflict   <= multi_s;
      if (multi_s) begin
        conflict_sticky <= 1'b1;
        conflict_cnt    <= (cnt_base_s == CNT_MAX) ? cnt_base_s
                                                   : cnt_base_s + CNT_W'(1);
      end else begin
        conflict_sticky <= conflict_sticky & ~err_clr;
        conflict_cnt    <= cnt_base_s;
      end
    end
  end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised successor to the CPU's combinational datapath bus multiplexer.
- Selects one of NSRC WIDTH-bit sources onto the shared datapath bus, using per-source output-enable strobes.
- Output is registered, with defined priority and hold-last-value when idle.
- Multi-driver conflicts are detected and logged: registered conflict pulse, sticky flag, saturating counter.
- Sits between the register file, PC, IR, MDR and immediate sources and every bus consumer, and gives the control unit a debug/error channel.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 21, number of bus sources; index i maps to sel[i] and busi[i*WIDTH +: WIDTH].
- CNT_W, 8, width of the saturating conflict counter.
- IDX_W, $clog2(NSRC), width of the source-index output; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- busi  input  NSRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- sel  input  NSRC  per-source output enables (the encoder strobes, e.g. pco, iro, r0o...).
- err_clr  input  1  clears conflict_sticky and conflict_cnt.
- buso  output  WIDTH  registered bus value.
- buso_valid  output  1  high for one cycle after a cycle in which any sel bit was set.
- src_idx  output  IDX_W  index of the source that produced the current buso.
- conflict  output  1  registered pulse: the previous cycle had two or more sel bits set.
- conflict_sticky  output  1  set on any conflict; held until err_clr or clr.
- conflict_cnt  output  CNT_W  number of conflict cycles, saturating.

Behaviour:
- Reset: clk is the only clock. clr is sampled on the rising edge, is active-high, and overrides every other input. On clr:
  - buso=0, buso_valid=0, src_idx=0
  - conflict=0, conflict_sticky=0, conflict_cnt=0
- Latency: sel and busi sampled at edge N appear on buso, src_idx and buso_valid after edge N. Latency is 1 cycle, with no combinational path from input to output.
- Priority: the highest asserted index wins. For example, sel[3] and sel[17] both set selects source 17.
- Idle (sel==0):
  - buso and src_idx hold their previous values.
  - buso_valid=0.
  - Counters are unchanged.
- Single select: buso=busi[k], src_idx=k, buso_valid=1, conflict=0.
- Conflict (popcount(sel)>=2):
  - The winner is driven as per the priority rule, and buso_valid=1.
  - conflict=1 for exactly one cycle.
  - conflict_sticky is set to 1.
  - conflict_cnt increments by 1 and saturates at 2^CNT_W-1; it never wraps.
- err_clr alone: conflict_sticky=0 and conflict_cnt=0 on the next edge. The conflict pulse is unaffected.
- err_clr and a conflict in the same cycle: the clear is applied first, then the new event is logged. Result: conflict_sticky=1, conflict_cnt=1.
- clr mid-operation: all outputs return to reset values on the next edge, regardless of sel or err_clr. Nothing in flight survives.
- Width rules:
  - src_idx is zero-extended to IDX_W.
  - NSRC=1 is legal; IDX_W is then forced to 1.
  - sel bits at or above NSRC do not exist.
- No X propagation: every path is driven under every sel combination, with no inferred latches.

Decomposition:
- Shared package cpu_bus_pkg contains:
  - source-index localparams matching the CPU datapath: SRC_PC=0, SRC_IR=1, SRC_R0..SRC_R15=2..17, SRC_MDR=18, SRC_IP=19, SRC_CSIGN=20.
  - NSRC_DEFAULT=21.
  - WIDTH_DEFAULT=32.
- Sub-module bus_prio_enc is combinational and parametrised on NSRC. It takes sel and produces:
  - idx: the highest set bit.
  - any: reduction OR of sel.
  - multi: two or more bits set.
- bus_mux_reg instantiates bus_prio_enc, indexes busi with idx, and registers the outputs and the conflict logic.

Test Plan:
- Reset: drive clr=1 for 2 cycles with sel=all ones -> buso=0, buso_valid=0, src_idx=0, conflict=0, conflict_cnt=0.
- Single source and hold:
  - busi[SRC_PC]=0x0000_1234 and sel=1<<0 for one cycle -> next cycle buso=0x1234, src_idx=0, buso_valid=1.
  - then sel=0 for 3 cycles -> buso stays 0x1234, buso_valid=0.
- Priority conflict: sel[SRC_R0] and sel[SRC_MDR] set, busi[2]=0xAAAA_AAAA, busi[18]=0x5555_5555 -> buso=0x5555_5555, src_idx=18, conflict=1 for 1 cycle, conflict_sticky=1, conflict_cnt=1.
- Saturation: with CNT_W=3, drive 10 consecutive conflict cycles -> conflict_cnt counts 1..7 then stays 7. conflict stays 1 on each following cycle.
- Simultaneous clear: with conflict_cnt=5, assert err_clr together with a conflict -> conflict_cnt=1, conflict_sticky=1. Next, err_clr alone -> conflict_cnt=0, conflict_sticky=0.
- Reset mid-operation: during a conflict burst with conflict_cnt=4, assert clr together with err_clr and sel=0x3 -> next cycle all outputs at reset values. First conflict after release gives conflict_cnt=1.
